// File: rtl/rice_core_muldiv.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module rice_core_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_operation,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_result_ready,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;

  logic                s1, s2, div_zero, div_ovf, fast;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    valid_d   = valid_q;

    // Signedness of each operand follows funct3: MULH/MULHSU sign rs1, only MULH signs rs2.
    if (i_operation[2]) begin
      s1 = !i_operation[0] && i_rs1_value[XLEN-1];
      s2 = !i_operation[0] && i_rs2_value[XLEN-1];
    end else begin
      s1 = (i_operation[1:0] == 2'b01 || i_operation[1:0] == 2'b10) && i_rs1_value[XLEN-1];
      s2 = (i_operation[1:0] == 2'b01) && i_rs2_value[XLEN-1];
    end
    mag1     = s1 ? -i_rs1_value : i_rs1_value;
    mag2     = s2 ? -i_rs2_value : i_rs2_value;
    div_zero = (i_rs2_value == '0);
    div_ovf  = !i_operation[0] && (i_rs1_value == MIN_INT) && (i_rs2_value == '1);
    fast     = i_operation[2] && (div_zero || div_ovf);

    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q, a_q[XLEN-1]};
    // Partial remainder stays below twice the divisor, so bit XLEN is a valid borrow flag.
    div_diff  = div_shift - {1'b0, b_q};
    prod_fix  = neg_q ? -prod_q : prod_q;
    quo_fix   = neg_q ? -a_q : a_q;
    rem_fix   = rem_neg_q ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (i_valid && !i_flush) begin
          op_d      = i_operation[1:0];
          cnt_d     = '0;
          neg_d     = s1 ^ s2;
          rem_neg_d = s1;
          rem_d     = '0;
          prod_d    = '0;
          if (fast) begin
            a_d     = i_rs1_value;
            b_d     = i_rs2_value;
            state_d = DONE;
          end else if (i_operation[2]) begin
            a_d     = mag1;
            b_d     = mag2;
            state_d = DIV;
          end else begin
            a_d     = mag1;
            b_d     = '0;
            prod_d  = {{XLEN{1'b0}}, mag2};
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (cnt_q == CNT_MAX) begin
          result_d = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DIV: begin
        if (cnt_q == CNT_MAX) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          if (!div_diff[XLEN]) begin
            rem_d = div_diff[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = div_shift[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // DONE entered without a result means a fast-path op; operands were kept raw.
        if (!valid_q) begin
          if (b_q == '0) result_d = op_q[1] ? a_q : '1;
          else           result_d = op_q[1] ? '0 : a_q;
          valid_d = 1'b1;
        end else if (i_result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_rice_core_muldiv.sv
// Self-checking bench for rice_core_muldiv (XLEN=32): directed corner cases,
// randomized ops against an arithmetic reference model, backpressure, flush and reset.
module tb_rice_core_muldiv;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_operation;
  logic [31:0] i_rs1_value;
  logic [31:0] i_rs2_value;
  logic        i_flush;
  logic        o_valid;
  logic        i_result_ready;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  rice_core_muldiv #(.XLEN(32)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_operation    (i_operation),
    .i_rs1_value    (i_rs1_value),
    .i_rs2_value    (i_rs2_value),
    .i_flush        (i_flush),
    .o_valid        (o_valid),
    .i_result_ready (i_result_ready),
    .o_result       (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model straight from the RISC-V M definitions using wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_operation = op;
    i_rs1_value = a;
    i_rs2_value = b;
    i_valid     = 1'b1;
    @(posedge i_clk); #1;
    i_valid     = 1'b0;
    i_rs1_value = $urandom;
    i_rs2_value = $urandom;
    i_operation = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 200) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    start_op(op, a, b);
    i_result_ready = 1'b1;
    wait_valid(lat);
    res = o_result;
    @(posedge i_clk); #1;
    i_result_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n_checks++;
    if ({o_ready, o_valid, o_result} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got ready=%0b valid=%0b result=%h, want 1 0 00000000",
               o_ready, o_valid, o_result);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [10] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    logic [31:0] as  [10] = '{32'd7, MIN_INT, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, MIN_INT};
    logic [31:0] bs  [10] = '{32'hFFFF_FFFD, MIN_INT, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] exp [10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'h7FFF_FFFC, 32'd1, 32'hFFFF_FFFF, 32'd7, MIN_INT};
    int          lats[10] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++;
      if (res !== exp[i]) begin
        n_fail++;
        $display("[TB] FAIL directed_%0d op=%0d result: got %h, want %h", i, ops[i], res, exp[i]);
      end
      n_checks++;
      if (lat != lats[i]) begin
        n_fail++;
        $display("[TB] FAIL directed_%0d op=%0d latency: got %0d, want %0d", i, ops[i], lat, lats[i]);
      end
    end
    // REM of the signed-overflow case is exercised separately so its zero result is distinct.
    run_op(3'd6, MIN_INT, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'h0 || lat != 1) begin
      n_fail++;
      $display("[TB] FAIL rem_overflow: got %h lat %0d, want 00000000 lat 1", res, lat);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          lat, mode;
    for (int i = 0; i < 48; i++) begin
      op   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = MIN_INT; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(1, 5)); end
      run_op(op, a, b, res, lat);
      n_checks++;
      if (res !== model(op, a, b) || lat != model_latency(op, a, b)) begin
        n_fail++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got %h lat %0d, want %h lat %0d",
                 i, op, a, b, res, lat, model(op, a, b), model_latency(op, a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    start_op(3'd2, 32'hFFFF_0003, 32'h0001_0005);
    wait_valid(lat);
    res = o_result;
    n_checks++;
    if (res !== model(3'd2, 32'hFFFF_0003, 32'h0001_0005) || lat != 33) begin
      n_fail++;
      $display("[TB] FAIL backpressure_result: got %h lat %0d, want %h lat 33",
               res, lat, model(3'd2, 32'hFFFF_0003, 32'h0001_0005));
    end
    for (int i = 0; i < 5; i++) begin
      i_valid     = 1'b1;
      i_operation = 3'd0;
      i_rs1_value = 32'd9;
      i_rs2_value = 32'd9;
      @(posedge i_clk); #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_result !== res || o_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL backpressure_hold_%0d: got valid=%0b result=%h ready=%0b, want 1 %h 0",
                 i, o_valid, o_result, o_ready, res);
      end
    end
    i_result_ready = 1'b1;
    @(posedge i_clk); #1;
    i_valid        = 1'b0;
    i_result_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL backpressure_release: got valid=%0b ready=%0b, want 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          lat;
    bit          pulse;
    start_op(3'd5, 32'd1000, 32'd7);
    repeat (9) @(posedge i_clk);
    #1;
    i_flush     = 1'b1;
    i_valid     = 1'b1;
    i_operation = 3'd0;
    i_rs1_value = 32'd2;
    i_rs2_value = 32'd3;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_idle: got ready=%0b valid=%0b, want 1 0", o_ready, o_valid);
    end
    i_result_ready = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1 || o_ready !== 1'b1) pulse = 1'b1;
    end
    i_result_ready = 1'b0;
    n_checks++;
    if (pulse) begin
      n_fail++;
      $display("[TB] FAIL flush_quiet: got activity=1 after flush, want 0");
    end
    run_op(3'd5, 32'd100, 32'd7, res, lat);
    n_checks++;
    if (res !== 32'd14 || lat != 33) begin
      n_fail++;
      $display("[TB] FAIL flush_recover: got %h lat %0d, want 0000000e lat 33", res, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int          lat;
    start_op(3'd1, 32'h1234_5678, 32'h8765_4321);
    repeat (19) @(posedge i_clk);
    #1;
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_flush = 1'b0;
    n_checks++;
    if ({o_ready, o_valid, o_result} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_op: got ready=%0b valid=%0b result=%h, want 1 0 00000000",
               o_ready, o_valid, o_result);
    end
    run_op(3'd0, 32'd3, 32'd5, res, lat);
    n_checks++;
    if (res !== 32'd15 || lat != 33) begin
      n_fail++;
      $display("[TB] FAIL reset_then_mul: got %h lat %0d, want 0000000f lat 33", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat;
    run_op(3'd7, 32'd50, 32'd8, res, lat);
    n_checks++;
    if (o_ready !== 1'b1 || res !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_first: got ready=%0b result=%h, want 1 00000002", o_ready, res);
    end
    run_op(3'd3, 32'h0000_FFFF, 32'h0001_0000, res, lat);
    n_checks++;
    if (res !== 32'h0 || lat != 33) begin
      n_fail++;
      $display("[TB] FAIL back_to_back_second: got %h lat %0d, want 00000000 lat 33", res, lat);
    end
  endtask

  initial begin
    i_rst          = 1'b1;
    i_valid        = 1'b0;
    i_flush        = 1'b0;
    i_result_ready = 1'b0;
    i_operation    = 3'd0;
    i_rs1_value    = 32'h0;
    i_rs2_value    = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rice_core_muldiv.md
RICE_CORE_MULDIV -- requirements
Module: rice_core_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  unit idle and able to accept a request.
REQ-006 SHALL have port i_operation  input  3  operation code, RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port i_rs1_value  input  XLEN  operand 1 (multiplicand or dividend).
REQ-008 SHALL have port i_rs2_value  input  XLEN  operand 2 (multiplier or divisor).
REQ-009 SHALL have port i_flush  input  1  abort any in-flight operation.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port i_result_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port o_result  output  XLEN  result value.

Function
REQ-013 SHALL implement a state machine with states IDLE, MUL, DIV and DONE; o_ready is 1 only in IDLE.
REQ-014 SHALL accept a request on an edge where i_valid, o_ready and !i_flush are all 1, capturing the operation and both operands; operands are ignored after that edge.
REQ-015 SHALL transition IDLE->MUL for op[2]=0 and IDLE->DIV for op[2]=1, except for the fast-path cases in REQ-019/REQ-020.
REQ-016 SHALL compute MUL-class operations by radix-2 shift-add on operand magnitudes over exactly XLEN cycles, then negate the 2*XLEN product when the operand signs differ; MULH is signed x signed, MULHSU is signed x unsigned, MULHU is unsigned x unsigned.
REQ-017 SHALL return product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-018 SHALL compute DIV-class operations by restoring division on magnitudes over exactly XLEN cycles; the quotient sign is the XOR of the operand signs and the remainder sign is the dividend sign (signed ops only).
REQ-019 SHALL handle a divisor of 0 by fast path: DIV/DIVU return all ones and REM/REMU return the dividend.
REQ-020 SHALL handle signed overflow (DIV/REM, dividend = 1<<(XLEN-1), divisor = all ones) by fast path: DIV returns the dividend and REM returns 0.
REQ-021 SHALL use this latency, counting the accept edge as edge 0: iterative ops raise o_valid after edge XLEN+1 (XLEN iteration cycles plus one sign-correction cycle); fast-path ops raise o_valid after edge 1.
REQ-022 SHALL keep o_result registered; in DONE, o_valid and o_result are held stable until i_result_ready=1, and the state returns to IDLE on that edge.
REQ-023 SHALL NOT accept a new request on the same edge that a result is retired; o_ready rises one cycle after retirement.
REQ-024 SHALL, when i_flush=1, move from any state to IDLE on that edge: o_valid=0 next cycle, the result is discarded, and a simultaneous i_valid is ignored.
REQ-025 SHALL use an iteration counter of $clog2(XLEN)+1 bits that saturates at XLEN and does not wrap.

Reset
REQ-026 SHALL, when i_rst=1 on an edge, including mid-operation, enter IDLE with o_ready=1, o_valid=0 and o_result=0 on the next cycle; i_rst has priority over i_flush and i_valid.
REQ-027 SHALL clear the operand, product, remainder and counter registers to 0 on reset.

Verification (XLEN=32)
REQ-028 SHALL cover: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; o_valid exactly 33 edges after accept.
REQ-029 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC; REMU -> 1.
REQ-030 SHALL cover: DIV 7 / 0 -> 0xFFFFFFFF and REM -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0; o_valid 1 edge after accept.
REQ-031 SHALL cover: i_result_ready held 0 for 5 cycles in DONE -> o_valid and o_result stable, o_ready=0, new i_valid ignored; release -> o_ready=1 one cycle later.
REQ-032 SHALL cover: i_flush at edge 10 of a DIVU with i_valid=1 simultaneously -> o_ready=1 next cycle, no o_valid pulse, the new request not accepted.
REQ-033 SHALL cover: i_rst at edge 20 of a MULH -> o_valid=0, o_result=0, o_ready=1 next cycle; a subsequent MUL 3 x 5 -> 15.
